cnff_sched: RTL and testbench
=============================

CNFF_SCHED -- requirements
Module: cnff_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter NBITS, default 8, SHALL set the number of C-N state bits in the bank; IDXW = clog2(NBITS).
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req  input  NREQ  SHALL carry the per-requester command-request lines, held high until granted.
REQ-006 req_idx  input  NREQ*IDXW  SHALL carry the flattened target bit index per requester; slice i belongs to requester i.
REQ-007 req_c, req_n  input  NREQ each  SHALL carry the C and N command bits per requester.
REQ-008 gnt  output  NREQ  SHALL be a registered, one-hot, single-cycle grant pulse.
REQ-009 rsp_valid  output  1  SHALL be a single-cycle response strobe.
REQ-010 rsp_id  output  clog2(NREQ)  SHALL identify the served requester; rsp_q (1) SHALL give the updated bit; rsp_err (1) SHALL flag an out-of-range index.
REQ-011 bank_q  output  NBITS  SHALL expose all C-N bits; busy (1) SHALL be high whenever the FSM is not in IDLE.

Function
REQ-012 Each bank bit SHALL obey the C-N rule: N=0 hold; N=1,C=0 clear; N=1,C=1 toggle (next = N ? C & ~Q : Q).
REQ-013 FSM states SHALL be IDLE, APPLY and RESP; IDLE->APPLY when any req is high; APPLY->RESP always; RESP->IDLE always.
REQ-014 In IDLE with any req high, the arbiter SHALL select winner w and latch req_idx, req_c and req_n of w.
REQ-015 gnt[w] SHALL be high during the APPLY cycle only, and the target bit SHALL update at the end of APPLY.
REQ-016 In RESP, rsp_valid SHALL be 1, with rsp_id = w and rsp_q = the post-update bit value.
REQ-017 Latency SHALL be: request seen in IDLE at cycle T -> gnt at T+1 -> rsp_valid at T+2; peak throughput SHALL be one command per 3 cycles.
REQ-018 Requests SHALL not be sampled in APPLY or RESP; a req dropped before its grant SHALL not be served.
REQ-019 Default arbitration SHALL be round-robin: after granting w, requester (w+1) mod NREQ SHALL have highest priority.
REQ-020 A latched idx >= NBITS SHALL leave the bank unchanged, still assert gnt, and return rsp_err=1 and rsp_q=0.
REQ-021 At most one bank bit SHALL change per command; all other bits SHALL hold.

Reset
REQ-022 reset SHALL force the FSM to IDLE, bank_q to 0, gnt to 0, rsp_valid/rsp_err/rsp_q to 0, rsp_id to 0, and the RR pointer to requester 0.
REQ-023 A reset asserted during APPLY or RESP SHALL abort the command, emit no response and discard the bank update.

Configuration
REQ-024 With macro CNFF_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and the RR pointer SHALL be omitted.
REQ-025 Without CNFF_SCHED_FIXED_PRIO_EN, round-robin per REQ-019 SHALL apply.

Structure
REQ-026 Package cnff_sched_pkg SHALL hold the state enum (IDLE/APPLY/RESP), the latched-command typedef (idx, c, n, id) and the C-N next-state function.
REQ-027 Sub-module cn_cell SHALL implement one bank bit (reset, enable, c, n -> q), instantiated NBITS times.

Verification
REQ-028 Reset, then req[1]=1 with idx=3, C=1, N=1 -> gnt=0010 at T+1; bank_q[3]=1, rsp_valid=1, rsp_id=1, rsp_q=1 at T+2.
REQ-029 Repeat the same command -> bank_q[3] toggles to 0; then C=0, N=0 -> hold at 0; then C=0, N=1 on a set bit -> cleared.
REQ-030 req=1111 held continuously, RR build -> grant order 0,1,2,3,0, one grant every 3 cycles; with FIXED_PRIO_EN -> always requester 0.
REQ-031 NBITS=6, idx=7 -> gnt pulses, bank_q unchanged, rsp_err=1, rsp_q=0.
REQ-032 reset asserted in the APPLY cycle -> no rsp_valid, bank_q=0, FSM in IDLE next cycle.
REQ-033 req[2] raised during RESP and held -> granted at the cycle after return to IDLE plus 1; a req pulsed only during APPLY -> never granted.

Source files
------------

// File: rtl/cnff_sched_pkg.sv
// Shared types and helpers for the C-N flip-flop bank scheduler.
package cnff_sched_pkg;

  // Field widths for a latched command; wide enough for up to 8 requesters
  // and a bank index of up to 8 bits.
  localparam int CMD_IDX_W = 8;
  localparam int CMD_ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMD_IDX_W-1:0] idx;
    logic                 c;
    logic                 n;
    logic [CMD_ID_W-1:0]  id;
  } cmd_t;

  // C-N rule: N=0 holds, N=1/C=0 clears, N=1/C=1 toggles.
  function automatic logic cn_next(input logic q, input logic c, input logic n);
    return n ? (c & ~q) : q;
  endfunction

endpackage

// File: rtl/cnff_sched_cn_cell.sv
// One C-N state bit of the bank; updates only when enabled.
module cn_cell
  import cnff_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic c,
  input  logic n,
  output logic q
);

  // Apply the C-N rule on an enabled cycle, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= cn_next(q, c, n);
    end
  end

endmodule

// File: rtl/cnff_sched.sv
// Arbitrated command scheduler for a bank of C-N flip-flops.
// Each command goes IDLE -> APPLY -> RESP: grant in APPLY, bank update at
// the end of APPLY, response strobe in RESP.
// Define CNFF_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise arbitration is round-robin.
module cnff_sched
  import cnff_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NBITS = 8,
  localparam int IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ-1:0]      req_c,
  input  logic [NREQ-1:0]      req_n,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_q,
  output logic                 rsp_err,
  output logic [NBITS-1:0]     bank_q,
  output logic                 busy
);

  state_t         state;
  state_t         state_nxt;
  cmd_t           cmd;
  logic [IDW-1:0] win;
  logic           any_req;
  logic           take;
  logic           oor;
  logic           cur_q;
  logic           new_q;
  int             sel;

  assign any_req = |req;
  assign take    = (state == IDLE) && any_req;
  assign oor     = cmd.idx >= CMD_IDX_W'(NBITS);
  assign new_q   = cn_next(cur_q, cmd.c, cmd.n);

`ifndef CNFF_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0] rr_ptr;

  // Round-robin pointer: the requester after the last winner goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= IDW'((int'(win) + 1) % NREQ);
    end
  end
`endif

  // Pick the winner by scanning requesters starting at the priority head.
  always_comb begin
    win = '0;
    sel = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef CNFF_SCHED_FIXED_PRIO_EN
      sel = k;
`else
      sel = (int'(rr_ptr) + k) % NREQ;
`endif
      if (req[sel]) begin
        win = IDW'(sel);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and busy flag.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_nxt = APPLY;
        end
      end
      APPLY:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's command and raise its grant for the APPLY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd <= '0;
      gnt <= '0;
    end else if (take) begin
      cmd.idx <= CMD_IDX_W'(req_idx[int'(win)*IDXW +: IDXW]);
      cmd.c   <= req_c[win];
      cmd.n   <= req_n[win];
      cmd.id  <= CMD_ID_W'(win);
      gnt     <= NREQ'(1) << win;
    end else begin
      gnt <= '0;
    end
  end

  // Current value of the targeted bit, zero when the index is out of range.
  always_comb begin
    cur_q = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      if (cmd.idx == CMD_IDX_W'(k)) begin
        cur_q = bank_q[k];
      end
    end
  end

  // Response for the command finishing APPLY, shown during RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state == APPLY) begin
      rsp_valid <= 1'b1;
      rsp_id    <= IDW'(cmd.id);
      rsp_q     <= oor ? 1'b0 : new_q;
      rsp_err   <= oor;
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= 1'b0;
      rsp_err   <= 1'b0;
    end
  end

  for (genvar k = 0; k < NBITS; k++) begin : g_bank
    cn_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .en   ((state == APPLY) && !oor && (cmd.idx == CMD_IDX_W'(k))),
      .c    (cmd.c),
      .n    (cmd.n),
      .q    (bank_q[k])
    );
  end

endmodule

// File: tb/tb_cnff_sched.sv
// Self-checking bench for cnff_sched: transaction-level model plus
// directed scenarios and a randomized run.
module tb_cnff_sched;

  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int IDXW  = 3;
  localparam int IDW   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      req_c;
  logic [NREQ-1:0]      req_n;
  logic [NREQ-1:0]      gnt;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_q;
  logic                 rsp_err;
  logic [NBITS-1:0]     bank_q;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  cnff_sched #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_idx  (req_idx),
    .req_c    (req_c),
    .req_n    (req_n),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_q    (rsp_q),
    .rsp_err  (rsp_err),
    .bank_q   (bank_q),
    .busy     (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a command occupies three cycles; the winner is the
  // first requesting index at or after the priority head.
  int              m_phase = 0;
  int              m_ptr   = 0;
  int              m_w     = 0;
  int              m_idx   = 0;
  bit              m_c, m_n;
  logic [NBITS-1:0] m_bank = '0;
  logic [NREQ-1:0]  e_gnt  = '0;
  bit              e_rv, e_q, e_err, e_rst;
  int              e_id;

  always @(posedge clk) begin
    cyc++;
    e_rst = reset;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_bank = '0; e_gnt = '0;
      e_rv = 0; e_q = 0; e_err = 0; e_id = 0;
    end else if (m_phase == 0) begin
      e_rv = 0; e_q = 0; e_err = 0; e_id = 0;
      if (req != '0) begin
        m_w = -1;
        for (int k = 0; k < NREQ; k++) begin
          int cand;
          cand = (m_ptr + k) % NREQ;
          if (m_w < 0 && req[cand]) m_w = cand;
        end
        m_idx = int'(req_idx[m_w*IDXW +: IDXW]);
        m_c   = req_c[m_w];
        m_n   = req_n[m_w];
`ifndef CNFF_SCHED_FIXED_PRIO_EN
        m_ptr = (m_w + 1) % NREQ;
`endif
        e_gnt   = NREQ'(1) << m_w;
        m_phase = 1;
      end else begin
        e_gnt = '0;
      end
    end else if (m_phase == 1) begin
      bit old_v, new_v;
      e_gnt = '0;
      if (m_idx < NBITS) begin
        old_v = m_bank[m_idx];
        if (!m_n)      new_v = old_v;
        else if (!m_c) new_v = 1'b0;
        else           new_v = !old_v;
        m_bank[m_idx] = new_v;
        e_q = new_v; e_err = 0;
      end else begin
        e_q = 0; e_err = 1;
      end
      e_rv = 1; e_id = m_w;
      m_phase = 2;
    end else begin
      e_gnt = '0; e_rv = 0; e_q = 0; e_err = 0; e_id = 0;
      m_phase = 0;
    end
  end

  int gq[$];
  int gcyc[$];

  // Compare DUT against the model every cycle and log grant events.
  always @(posedge clk) begin
    #1;
    checkOutput("gnt", 32'(gnt), 32'(e_gnt));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    checkOutput("busy", 32'(busy), 32'(m_phase != 0));
    checkOutput("bank_q", 32'(bank_q), 32'(m_bank));
    if (e_rv || e_rst) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(e_id));
      checkOutput("rsp_q", 32'(rsp_q), 32'(e_q));
      checkOutput("rsp_err", 32'(rsp_err), 32'(e_err));
    end
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        gq.push_back(k);
        gcyc.push_back(cyc);
      end
    end
  end

  task automatic applyStimulus(input int r, input int idx, input bit c, input bit n);
    logic [31:0] iv;
    iv = 32'(idx);
    req_idx[r*IDXW +: IDXW] = iv[IDXW-1:0];
    req_c[r] = c;
    req_n[r] = n;
  endtask

  // One isolated command with hand-computed expected response.
  task automatic runCmd(input int r, input int idx, input bit c, input bit n,
                        input bit exp_q, input bit exp_err);
    applyStimulus(r, idx, c, n);
    req[r] = 1'b1;
    @(negedge clk);
    checkOutput("cmd_gnt", 32'(gnt), 32'(1) << r);
    req[r] = 1'b0;
    @(negedge clk);
    checkOutput("cmd_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("cmd_rsp_id", 32'(rsp_id), 32'(r));
    checkOutput("cmd_rsp_q", 32'(rsp_q), 32'(exp_q));
    checkOutput("cmd_rsp_err", 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; req_idx = '0; req_c = '0; req_n = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_bank", 32'(bank_q), 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed C-N commands");
    runCmd(1, 3, 1, 1, 1, 0);
    checkOutput("bank_set3", 32'(bank_q), 32'h08);
    runCmd(1, 3, 1, 1, 0, 0);
    checkOutput("bank_toggle3", 32'(bank_q), 32'h00);
    runCmd(1, 3, 0, 0, 0, 0);
    checkOutput("bank_hold3", 32'(bank_q), 32'h00);
    runCmd(0, 2, 1, 1, 1, 0);
    checkOutput("bank_set2", 32'(bank_q), 32'h04);
    runCmd(2, 2, 0, 1, 0, 0);
    checkOutput("bank_clear2", 32'(bank_q), 32'h00);
    runCmd(1, 5, 1, 1, 1, 0);
    runCmd(2, 5, 0, 0, 1, 0);
    checkOutput("bank_hold5", 32'(bank_q), 32'h20);
    runCmd(3, 7, 1, 1, 0, 1);
    checkOutput("bank_oor", 32'(bank_q), 32'h20);

    $display("[TB] all requesters held");
    gq.delete(); gcyc.delete();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, i, 1'b1, 1'b1);
    req = '1;
    repeat (13) @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    checkOutput("arb_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
`ifdef CNFF_SCHED_FIXED_PRIO_EN
      checkOutput("arb_order", 32'(gq[i]), 32'd0);
`else
      checkOutput("arb_order", 32'(gq[i]), 32'(i % NREQ));
`endif
      if (i > 0) checkOutput("arb_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end

    $display("[TB] reset during APPLY");
    applyStimulus(0, 4, 1, 1);
    req[0] = 1'b1;
    @(negedge clk);
    checkOutput("abort_gnt", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_bank", 32'(bank_q), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] request timing around RESP and APPLY");
    applyStimulus(0, 1, 1, 1);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    checkOutput("late_rsp_valid", 32'(rsp_valid), 32'd1);
    applyStimulus(2, 0, 1, 1);
    req[2] = 1'b1;
    @(negedge clk);
    checkOutput("late_no_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    checkOutput("late_gnt2", 32'(gnt), 32'h4);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(3, 0, 1, 1);
    req[3] = 1'b1;
    @(negedge clk);
    req[3] = 1'b0;
    applyStimulus(1, 1, 1, 1);
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    checkOutput("pulse_no_gnt_a", 32'(gnt), 32'd0);
    @(negedge clk);
    checkOutput("pulse_no_gnt_b", 32'(gnt), 32'd0);
    checkOutput("pulse_idle", 32'(busy), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      req     = NREQ'($urandom);
      req_idx = (NREQ*IDXW)'($urandom);
      req_c   = NREQ'($urandom);
      req_n   = NREQ'($urandom);
      reset   = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    req   = '0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
